// File: rtl/pipe_mem_sched_pkg.sv
// Shared definitions for the pipeline/memory sequencer.
//   state_t        : FSM encoding (S_ISSUE=0, S_DATA=1, S_FETCH=2)
//   MEM_SEL_FETCH  : mem_sel value routing the fetch address/port
//   MEM_SEL_DATA   : mem_sel value routing the data address/port
//   REG_ZERO       : architectural x0, never a real hazard source
package pipe_mem_sched_pkg;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_DATA  = 2'd1,
    S_FETCH = 2'd2
  } state_t;

  localparam logic MEM_SEL_FETCH = 1'b0;
  localparam logic MEM_SEL_DATA  = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_mem_sched_hazard_detect.sv
// Load-use hazard compare.
// Ports:
//   ex_mem_read : instruction in EX is a load
//   ex_rd       : EX destination register
//   id_rs1/2    : ID source registers
//   stall       : 1 when the ID instruction consumes the pending load result
module hazard_detect
  import pipe_mem_sched_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       stall
);

  // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign stall = ex_mem_read && (ex_rd != REG_ZERO) &&
                 ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_mem_sched.sv
// Sequences the 5-stage pipeline around a single-ported unified memory.
// Each step: optional data access (S_DATA), instruction fetch (S_FETCH),
// and the cycle in which the fetch completes is the advance cycle that
// loads/flushes the PC and pipeline registers.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   mem_ready            : memory finished the current request this cycle
//   dmem_req             : MEM-stage instruction needs a load/store
//   ex_mem_read, ex_rd   : EX-stage load info for load-use detection
//   id_rs1, id_rs2       : ID-stage source registers
//   branch_taken         : taken branch resolved in MEM
//   mem_req, mem_sel     : memory request valid / port select (0 fetch, 1 data)
//   pc_load, *_load      : register load enables (advance cycle only)
//   *_flush              : force register input to NOP/zero
//   mem_err              : sticky timeout flag (TIMEOUT cycles without mem_ready)
// Optional build macro PIPE_MEM_SCHED_PERF_EN adds CNT_W-wide counters
// cyc_cnt, stall_cnt and flush_cnt.
module pipe_mem_sched
  import pipe_mem_sched_pkg::*;
#(
  parameter int TIMEOUT = 16
`ifdef PIPE_MEM_SCHED_PERF_EN
  ,
  parameter int CNT_W   = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_ready,
  input  logic       dmem_req,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       branch_taken,
  output logic       mem_req,
  output logic       mem_sel,
  output logic       pc_load,
  output logic       ifid_load,
  output logic       idex_load,
  output logic       exmem_load,
  output logic       memwb_load,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       mem_err
`ifdef PIPE_MEM_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic          mem_err_q;
  logic          load_use;
  logic          waiting;
  logic          advance;
  logic          stall_eff;

  hazard_detect u_hazard (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .stall       (load_use)
  );

  assign waiting   = (state == S_DATA) || (state == S_FETCH);
  assign advance   = !rst && (state == S_FETCH) && mem_ready;
  // A taken branch squashes the dependent ID instruction anyway, so the stall is moot.
  assign stall_eff = load_use && !branch_taken;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ISSUE;
      tmo_cnt   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        S_ISSUE: state <= dmem_req ? S_DATA : S_FETCH;
        S_DATA:  if (mem_ready) state <= S_FETCH;
        S_FETCH: if (mem_ready) state <= S_ISSUE;
        default: state <= S_ISSUE;
      endcase

      // Counter saturates at TIMEOUT; the FSM keeps waiting after the error.
      if (waiting && !mem_ready) begin
        if (tmo_cnt != TW'(TIMEOUT)) tmo_cnt <= tmo_cnt + TW'(1);
        if (tmo_cnt == TW'(TIMEOUT - 1)) mem_err_q <= 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  // NOTE: every output gets a default before the conditional logic so no
  // path leaves a signal unassigned (which would infer a latch).
  always_comb begin
    mem_req     = 1'b0;
    mem_sel     = MEM_SEL_FETCH;
    pc_load     = 1'b0;
    ifid_load   = 1'b0;
    idex_load   = 1'b0;
    exmem_load  = 1'b0;
    memwb_load  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (!rst) begin
      mem_req = waiting;
      if (state == S_DATA) mem_sel = MEM_SEL_DATA;
    end
    if (advance) begin
      // On a stall the fetched word is dropped (PC and IF/ID hold) and a
      // bubble enters ID/EX; the instruction is refetched next step.
      pc_load     = !stall_eff;
      ifid_load   = !stall_eff;
      idex_load   = 1'b1;
      exmem_load  = 1'b1;
      memwb_load  = 1'b1;
      ifid_flush  = branch_taken;
      idex_flush  = branch_taken || stall_eff;
      exmem_flush = branch_taken;
    end
  end

  assign mem_err = mem_err_q && !rst;

`ifdef PIPE_MEM_SCHED_PERF_EN
  logic [CNT_W-1:0] cyc_q, stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (advance && stall_eff)    stall_q <= stall_q + CNT_W'(1);
      if (advance && branch_taken) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign cyc_cnt   = rst ? '0 : cyc_q;
  assign stall_cnt = rst ? '0 : stall_q;
  assign flush_cnt = rst ? '0 : flush_q;
`endif

endmodule

// File: tb/tb_pipe_mem_sched.sv
// Self-checking bench for pipe_mem_sched. Each step's expected advance
// vector, advance cycle, mem_sel/mem_req cycle counts are pushed to a
// scoreboard when the step is driven and popped when the step completes.
// Inputs are driven just after the falling edge; outputs sampled 1 ns later.
module tb_pipe_mem_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_ready = 1'b0;
  logic       dmem_req = 1'b0;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_rd = 5'd0;
  logic [4:0] id_rs1 = 5'd0;
  logic [4:0] id_rs2 = 5'd0;
  logic       branch_taken = 1'b0;
  logic       mem_req, mem_sel, pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  logic       ifid_flush, idex_flush, exmem_flush, mem_err;
`ifdef PIPE_MEM_SCHED_PERF_EN
  logic [31:0] cyc_cnt, stall_cnt, flush_cnt;
`endif

  pipe_mem_sched dut (
    .clk          (clk),
    .rst          (rst),
    .mem_ready    (mem_ready),
    .dmem_req     (dmem_req),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_sel      (mem_sel),
    .pc_load      (pc_load),
    .ifid_load    (ifid_load),
    .idex_load    (idex_load),
    .exmem_load   (exmem_load),
    .memwb_load   (memwb_load),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .mem_err      (mem_err)
`ifdef PIPE_MEM_SCHED_PERF_EN
    ,
    .cyc_cnt      (cyc_cnt),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {pc, ifid, idex, exmem, memwb loads, ifid, idex, exmem flushes}
  logic [7:0] obs_vec;
  assign obs_vec = {pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                    ifid_flush, idex_flush, exmem_flush};

  typedef struct {
    logic [7:0] vec;
    int         adv_cyc;
    int         sel_cyc;
    int         req_cyc;
    int         nz_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   run_cycles = 0;

  function automatic logic [7:0] model_vec(input logic emr, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic br);
    logic lu;
    lu = emr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    if (br)      return 8'b1111_1111;
    else if (lu) return 8'b0011_1010;
    else         return 8'b1111_1000;
  endfunction

  // Drives one full step, then pops its scoreboard entry and compares.
  task automatic run_step(input string tag, input logic dmem, input int dw, input int fw,
                          input logic issue_rdy, input logic emr, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic br);
    exp_t e, got;
    int   total;
    total     = 1 + (dmem ? dw + 1 : 0) + fw + 1;
    e.vec     = model_vec(emr, rd, rs1, rs2, br);
    e.adv_cyc = total;
    e.sel_cyc = dmem ? dw + 1 : 0;
    e.req_cyc = total - 1;
    e.nz_cyc  = 1;
    sb.push_back(e);

    dmem_req = dmem; ex_mem_read = emr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    branch_taken = br;
    got.vec = '0; got.adv_cyc = -1; got.sel_cyc = 0; got.req_cyc = 0; got.nz_cyc = 0;
    for (int c = 1; c <= total; c++) begin
      if (c == 1)                     mem_ready = issue_rdy;
      else if (dmem && c <= 2 + dw)   mem_ready = (c == 2 + dw);
      else                            mem_ready = (c == total);
      #1;
      if (mem_sel) got.sel_cyc++;
      if (mem_req) got.req_cyc++;
      if (obs_vec != 8'd0) begin
        got.nz_cyc++;
        if (got.adv_cyc < 0) begin
          got.adv_cyc = c;
          got.vec     = obs_vec;
        end
      end
      run_cycles++;
      @(negedge clk);
    end

    e = sb.pop_front();
    checks++;
    if (got.vec !== e.vec) begin
      errors++; $display("FAIL %s adv_vec got %b exp %b", tag, got.vec, e.vec);
    end
    checks++;
    if (got.adv_cyc != e.adv_cyc) begin
      errors++; $display("FAIL %s adv_cycle got %0d exp %0d", tag, got.adv_cyc, e.adv_cyc);
    end
    checks++;
    if (got.sel_cyc != e.sel_cyc) begin
      errors++; $display("FAIL %s mem_sel_cycles got %0d exp %0d", tag, got.sel_cyc, e.sel_cyc);
    end
    checks++;
    if (got.req_cyc != e.req_cyc) begin
      errors++; $display("FAIL %s mem_req_cycles got %0d exp %0d", tag, got.req_cyc, e.req_cyc);
    end
    checks++;
    if (got.nz_cyc != e.nz_cyc) begin
      errors++; $display("FAIL %s load_flush_cycles got %0d exp %0d", tag, got.nz_cyc, e.nz_cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; dmem_req = 1'b1; ex_mem_read = 1'b1;
    ex_rd = 5'd5; id_rs1 = 5'd5; branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({obs_vec, mem_req, mem_sel, mem_err} !== 11'd0) begin
        errors++;
        $display("FAIL reset_outputs got %b exp 0", {obs_vec, mem_req, mem_sel, mem_err});
      end
      @(negedge clk);
    end
    rst = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; branch_taken = 1'b0;
  endtask

  task automatic test_fetch_only();
    for (int i = 0; i < 3; i++)
      run_step("fetch_only", 1'b0, 0, 0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic test_data_access();
    run_step("data_access", 1'b1, 3, 2, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    run_step("data_nowait", 1'b1, 0, 0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic test_load_use();
    run_step("load_use_rs2", 1'b0, 0, 1, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0);
    run_step("load_use_rs1", 1'b1, 1, 0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd1, 1'b0);
    run_step("load_use_x0",  1'b0, 0, 0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    run_step("no_load",      1'b0, 0, 0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0);
  endtask

  task automatic test_branch();
    run_step("branch_over_stall", 1'b0, 0, 0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1);
    run_step("branch_data",       1'b1, 2, 1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
  endtask

  // Reset arriving mid data access must abandon it and restart in S_ISSUE.
  task automatic test_mid_reset();
    dmem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; ex_mem_read = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({mem_req, mem_sel} !== 2'b11) begin
      errors++; $display("FAIL mid_reset_data got %b exp 11", {mem_req, mem_sel});
    end
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if ({obs_vec, mem_req, mem_sel} !== 10'd0) begin
      errors++; $display("FAIL mid_reset_outputs got %b exp 0", {obs_vec, mem_req, mem_sel});
    end
    @(negedge clk);
    rst = 1'b0;
    run_step("after_mid_reset", 1'b0, 0, 0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic test_timeout();
    dmem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; ex_mem_read = 1'b0;
    @(negedge clk);                       // S_ISSUE
    for (int f = 1; f <= 17; f++) begin   // S_FETCH, no ready
      #1;
      if (f == 16) begin
        checks++;
        if (mem_err !== 1'b0) begin
          errors++; $display("FAIL timeout_early got %b exp 0", mem_err);
        end
      end
      if (f == 17) begin
        checks++;
        if (mem_err !== 1'b1) begin
          errors++; $display("FAIL timeout_set got %b exp 1", mem_err);
        end
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obs_vec !== 8'b1111_1000) begin
      errors++; $display("FAIL timeout_late_advance got %b exp 11111000", obs_vec);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_err !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky got %b exp 1", mem_err);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (mem_err !== 1'b0) begin
      errors++; $display("FAIL timeout_rst_forced got %b exp 0", mem_err);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (mem_err !== 1'b0) begin
      errors++; $display("FAIL timeout_rst_cleared got %b exp 0", mem_err);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      logic [4:0] rd, rs1, rs2;
      rd  = 5'($urandom_range(0, 3));
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      run_step("back_to_back", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), rd, rs1, rs2, 1'($urandom_range(0, 1)));
    end
  endtask

`ifdef PIPE_MEM_SCHED_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      case (i)
        1, 4, 7: run_step("perf_stall", 1'(i % 2), 1, 0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd2, 1'b0);
        2:       run_step("perf_branch", 1'b0, 0, 1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        8:       run_step("perf_branch_lu", 1'b1, 0, 0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd4, 1'b1);
        default: run_step("perf_plain", 1'(i % 2), 2, 1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      endcase
    end
    #1;
    checks++;
    if (stall_cnt !== 32'd3) begin
      errors++; $display("FAIL perf_stall_cnt got %0d exp 3", stall_cnt);
    end
    checks++;
    if (flush_cnt !== 32'd2) begin
      errors++; $display("FAIL perf_flush_cnt got %0d exp 2", flush_cnt);
    end
    checks++;
    if (cyc_cnt !== 32'(run_cycles)) begin
      errors++; $display("FAIL perf_cyc_cnt got %0d exp %0d", cyc_cnt, run_cycles);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_fetch_only();
    test_data_access();
    test_load_use();
    test_branch();
    test_mid_reset();
    test_timeout();
    test_back_to_back();
`ifdef PIPE_MEM_SCHED_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_mem_sched.md
Name: pipe_mem_sched

Overview:
- Sequences the 5-stage pipeline around a single-ported unified memory shared by instruction fetch (IF) and data access (MEM stage).
- Each pipeline step performs an optional data access, then a fetch, then one advance cycle.
- Drives load/flush enables of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB load-enabled registers; resolves load-use stalls and taken-branch flushes.
- Sits between the memory port and the pipeline registers in the core top level.

Parameters:
TIMEOUT, 16, cycles without mem_ready before mem_err is set
CNT_W, 32, width of perf counters (optional feature only)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
mem_ready  in  1  memory completed the current request this cycle
dmem_req  in  1  instruction in MEM stage needs a load/store
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  5  EX destination register
id_rs1  in  5  ID source register 1
id_rs2  in  5  ID source register 2
branch_taken  in  1  taken branch resolved in MEM stage
mem_req  out  1  memory request valid
mem_sel  out  1  0 = fetch address/port, 1 = data address/port
pc_load  out  1  PC register load
ifid_load, idex_load, exmem_load, memwb_load  out  1 each  pipeline register loads
ifid_flush, idex_flush, exmem_flush  out  1 each  force register input to NOP/zero
mem_err  out  1  sticky timeout flag

Behaviour:
- FSM states: S_ISSUE, S_DATA, S_FETCH.
- Reset: synchronous, so the state register samples rst only on the clk edge.
  - State goes to S_ISSUE; timeout counter and mem_err clear to 0.
  - While rst=1, every output is forced to 0, combinational ones included.
  - rst mid-access abandons the request; there is no completion or advance.
- S_ISSUE: mem_req=0. Next state is S_DATA if dmem_req=1, else S_FETCH. Costs one cycle per step.
- S_DATA: mem_req=1, mem_sel=1, all loads 0. On mem_ready, go to S_FETCH.
- S_FETCH: mem_req=1, mem_sel=0. On mem_ready, this cycle is the advance cycle; next state is S_ISSUE.
- Advance cycle (S_FETCH and mem_ready):
  - Default: all five loads = 1, all flushes = 0.
  - Load-use hazard = ex_mem_read and ex_rd != 0 and (ex_rd == id_rs1 or ex_rd == id_rs2).
    - Action: pc_load=0, ifid_load=0, idex_flush=1; idex/exmem/memwb loads stay 1.
    - The fetched word is discarded and refetched next step.
  - branch_taken=1: ifid_flush, idex_flush and exmem_flush = 1; pc_load=1 (PC mux selects target externally).
    - Branch has priority over load-use. When both are true, the branch action applies and the load-use stall is suppressed.
- All loads and flushes are 0 outside the advance cycle.
- Minimum step latency: 2 cycles without a data access; 3 + memory wait cycles with one.
- Timeout: a counter increments each cycle in S_DATA/S_FETCH without mem_ready and clears on mem_ready or on leaving the state.
  - When the count reaches TIMEOUT, mem_err is set (sticky until rst).
  - The FSM keeps waiting; no recovery.
- mem_ready in S_ISSUE is ignored.

Optional Feature:
- Macro: PIPE_MEM_SCHED_PERF_EN.
- Defined:
  - Adds outputs cyc_cnt, stall_cnt and flush_cnt, each CNT_W wide, reset to 0 and wrapping modulo 2^CNT_W.
  - cyc_cnt increments every non-reset cycle.
  - stall_cnt increments on each advance cycle with a load-use stall.
  - flush_cnt increments on each advance cycle with branch_taken.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding typedef (S_ISSUE=0, S_DATA=1, S_FETCH=2, 2 bits);
  - MEM_SEL_FETCH/MEM_SEL_DATA constants;
  - REG_ZERO=5'd0.
- One sub-module: hazard_detect, a combinational load-use compare returning a 1-bit stall.

Test Plan:
- rst=1 for 2 cycles, then release, dmem_req=0, mem_ready=1 always:
  - S_ISSUE→S_FETCH→advance every 2nd cycle;
  - all 5 loads pulse 1 for one cycle, mem_sel=0 throughout.
- dmem_req=1, mem_ready asserted after 3 wait cycles for data and 2 for fetch:
  - mem_sel=1 for 4 cycles, then 0 for 3;
  - advance on cycle 8 after S_ISSUE.
- ex_mem_read=1, ex_rd=5, id_rs2=5, at advance:
  - pc_load=0, ifid_load=0, idex_flush=1, exmem_load=memwb_load=1.
  - Repeat with ex_rd=0: no stall.
- branch_taken=1 together with the load-use condition at advance:
  - pc_load=1, three flushes=1, no stall.
- mem_ready held 0 in S_FETCH:
  - mem_err=1 after 16 cycles and stays 1 after mem_ready returns;
  - rst clears it.
- PIPE_MEM_SCHED_PERF_EN defined, 10 steps including 3 stalls and 2 branches:
  - stall_cnt=3, flush_cnt=2, cyc_cnt equals the elapsed cycle count.
